// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-gated, stretched, staggered reset release for the mclk domain.
//
// user_reset2 (active-low, async) clears every flop. Release goes through a
// SYNC_STAGES synchroniser. pll_lock is synchronised and then filtered. Reset is
// held for STRETCH cycles after the lock is good. The N_DOM outputs are then
// released bit 0 first, GAP cycles apart.
//
// Optional build macro RST_CAUSE_EN adds the rst_cause[1:0] output:
//   00 = user_reset2, 01 = lock loss, 10 = software request.
//
// sw_reset_req protocol: a single-cycle, mclk-synchronous pulse with no ready
// or acknowledge. It is sampled on every edge and acted on only in RELEASE or
// RUN. In every other state it is dropped without being queued.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int N_DOM       = 4,
  parameter int LOCK_FILT   = 8,
  parameter int STRETCH     = 16,
  parameter int GAP         = 8
) (
  input  logic             mclk,
  input  logic             user_reset2,
  input  logic             pll_lock,
  input  logic             sw_reset_req,
  output logic [N_DOM-1:0] sync_reset_n,
  output logic             rst_done,
  output logic [2:0]       seq_state,
  output logic [7:0]       lock_loss_cnt
`ifdef RST_CAUSE_EN
  ,
  output logic [1:0]       rst_cause
`endif
);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam logic [15:0] STRETCH_LAST = 16'(STRETCH - 1);
  localparam logic [7:0]  GAP_LAST     = 8'(GAP - 1);
  localparam logic [7:0]  FILT_FULL    = 8'(LOCK_FILT);
  localparam bit          SINGLE_DOM   = (N_DOM == 1);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_int_n;
  logic                   lock_s;
  logic [7:0]             filt_cnt;
  logic                   lock_ok;

  state_t                 state, state_nxt;
  logic [15:0]            stretch_cnt, stretch_nxt;
  logic [7:0]             gap_cnt, gap_nxt;
  logic [N_DOM-1:0]       sync_nxt;
  logic [N_DOM-1:0]       sync_shift;
  logic                   done_nxt;
  logic [7:0]             loss_nxt;
`ifdef RST_CAUSE_EN
  logic [1:0]             cause_nxt;
`endif

  assign rst_int_n  = rst_sync[SYNC_STAGES-1];
  assign lock_s     = lock_sync[SYNC_STAGES-1];
  assign lock_ok    = (filt_cnt == FILT_FULL);
  assign seq_state  = state;
  // Next release pattern: one more low-order bit set, so bits only ever rise in order.
  assign sync_shift = N_DOM'({sync_reset_n, 1'b1});

  // Reset-release synchroniser: asserts asynchronously and releases after SYNC_STAGES edges.
  always_ff @(posedge mclk or negedge user_reset2) begin
    if (!user_reset2) rst_sync <= '0;
    else              rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // pll_lock synchroniser: the lock input is asynchronous to mclk.
  always_ff @(posedge mclk or negedge user_reset2) begin
    if (!user_reset2) lock_sync <= '0;
    else              lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
  end

  // Lock filter: counts consecutive synchronised lock-high cycles and saturates at LOCK_FILT.
  always_ff @(posedge mclk or negedge user_reset2) begin
    if (!user_reset2)          filt_cnt <= '0;
    else if (!rst_int_n)       filt_cnt <= '0;
    else if (!lock_s)          filt_cnt <= '0;
    else if (filt_cnt != FILT_FULL) filt_cnt <= filt_cnt + 8'd1;
  end

  // Sequencer registers: state, counters and the registered reset outputs.
  always_ff @(posedge mclk or negedge user_reset2) begin
    if (!user_reset2) begin
      state         <= ST_HOLD;
      stretch_cnt   <= '0;
      gap_cnt       <= '0;
      sync_reset_n  <= '0;
      rst_done      <= 1'b0;
      lock_loss_cnt <= '0;
`ifdef RST_CAUSE_EN
      rst_cause     <= 2'b00;
`endif
    end else begin
      state         <= state_nxt;
      stretch_cnt   <= stretch_nxt;
      gap_cnt       <= gap_nxt;
      sync_reset_n  <= sync_nxt;
      rst_done      <= done_nxt;
      lock_loss_cnt <= loss_nxt;
`ifdef RST_CAUSE_EN
      rst_cause     <= cause_nxt;
`endif
    end
  end

  // Next-state logic. Lock loss takes priority over a software request.
  always_comb begin
    state_nxt   = state;
    stretch_nxt = stretch_cnt;
    gap_nxt     = gap_cnt;
    sync_nxt    = sync_reset_n;
    done_nxt    = rst_done;
    loss_nxt    = lock_loss_cnt;
`ifdef RST_CAUSE_EN
    cause_nxt   = rst_cause;
`endif
    case (state)
      ST_HOLD: begin
        if (rst_int_n) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_nxt   = ST_STRETCH;
          stretch_nxt = '0;
        end
      end
      ST_STRETCH: begin
        if (!lock_ok) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (stretch_cnt == STRETCH_LAST) begin
          sync_nxt = N_DOM'(1);
          gap_nxt  = '0;
          if (SINGLE_DOM) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end else begin
          stretch_nxt = stretch_cnt + 16'd1;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lock_ok) begin
          state_nxt = ST_WAIT_LOCK;
          sync_nxt  = '0;
          done_nxt  = 1'b0;
          if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
`ifdef RST_CAUSE_EN
          cause_nxt = 2'b01;
`endif
        end else if (sw_reset_req) begin
          state_nxt   = ST_STRETCH;
          stretch_nxt = '0;
          sync_nxt    = '0;
          done_nxt    = 1'b0;
`ifdef RST_CAUSE_EN
          cause_nxt   = 2'b10;
`endif
        end else if (state == ST_RELEASE) begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt  = '0;
            sync_nxt = sync_shift;
            if (&sync_shift) begin
              state_nxt = ST_RUN;
              done_nxt  = 1'b1;
            end
          end else begin
            gap_nxt = gap_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a
// timestamp-based reference model. Build with RST_CAUSE_EN defined to also cover rst_cause.
module tb_reset_sequencer;

  localparam int SS = 2;
  localparam int ND = 4;
  localparam int LF = 8;
  localparam int ST = 16;
  localparam int GP = 8;

  logic          mclk = 1'b0;
  logic          user_reset2;
  logic          pll_lock;
  logic          sw_reset_req;
  logic [ND-1:0] sync_reset_n;
  logic          rst_done;
  logic [2:0]    seq_state;
  logic [7:0]    lock_loss_cnt;
`ifdef RST_CAUSE_EN
  logic [1:0]    rst_cause;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer #(.SYNC_STAGES(SS), .N_DOM(ND), .LOCK_FILT(LF), .STRETCH(ST), .GAP(GP)) dut (
    .mclk         (mclk),
    .user_reset2  (user_reset2),
    .pll_lock     (pll_lock),
    .sw_reset_req (sw_reset_req),
    .sync_reset_n (sync_reset_n),
    .rst_done     (rst_done),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt)
`ifdef RST_CAUSE_EN
    ,
    .rst_cause    (rst_cause)
`endif
  );

  // ---------------- clock ----------------
  always #5 mclk = ~mclk;

  // ---------------- checking task ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks edges since reset release (m_k). It also tracks the edge at
  // which the current stretch window began (m_t0). All outputs follow from the
  // elapsed time by plain arithmetic.
  localparam int M_HOLD = 0, M_WAIT = 1, M_SEQ = 2;
  int m_k, m_filt, m_mode, m_t0, m_loss, m_cause;
  bit m_lq[$];

  function automatic int m_state();
    int e;
    if (m_mode == M_HOLD) return 0;
    if (m_mode == M_WAIT) return 1;
    e = m_k - m_t0;
    if (e < ST) return 2;
    if (e >= ST + (ND - 1) * GP) return 4;
    return 3;
  endfunction

  function automatic logic [ND-1:0] m_sync();
    int e, n;
    if (m_mode != M_SEQ) return '0;
    e = m_k - m_t0;
    if (e < ST) return '0;
    n = 1 + (e - ST) / GP;
    if (n > ND) n = ND;
    return ND'((1 << n) - 1);
  endfunction

  function automatic bit m_lock_ok();
    return m_filt == LF;
  endfunction

  // Model update on each edge, using pre-edge model values and inputs.
  always @(posedge mclk or negedge user_reset2) begin
    if (!user_reset2) begin
      m_k = 0; m_filt = 0; m_mode = M_HOLD; m_t0 = 0; m_loss = 0; m_cause = 0;
      m_lq.delete();
      for (int i = 0; i < SS; i++) m_lq.push_back(1'b0);
    end else begin
      bit rst_ok, ls, lok;
      int st;
      rst_ok = (m_k >= SS);
      ls     = m_lq[SS-1];
      lok    = m_lock_ok();
      st     = m_state();
      m_k++;
      case (m_mode)
        M_HOLD: if (rst_ok) m_mode = M_WAIT;
        M_WAIT: if (lok) begin m_mode = M_SEQ; m_t0 = m_k; end
        default: begin
          if (st == 2) begin
            if (!lok) m_mode = M_WAIT;
          end else if (!lok) begin
            m_mode = M_WAIT;
            if (m_loss < 255) m_loss++;
            m_cause = 1;
          end else if (sw_reset_req) begin
            m_t0 = m_k;
            m_cause = 2;
          end
        end
      endcase
      if (!rst_ok || !ls) m_filt = 0;
      else if (m_filt < LF) m_filt++;
      m_lq.push_front(pll_lock);
      void'(m_lq.pop_back());
    end
  end

  // Scoreboard: compare every output against the model on each falling edge.
  always @(negedge mclk) begin
    check_eq("sync_reset_n", 32'(sync_reset_n), 32'(m_sync()));
    check_eq("rst_done", 32'(rst_done), 32'(m_state() == 4));
    check_eq("seq_state", 32'(seq_state), 32'(m_state()));
    check_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`ifdef RST_CAUSE_EN
    check_eq("rst_cause", 32'(rst_cause), 32'(m_cause));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge mclk);
  endtask

  task automatic do_reset(input logic lock_val);
    @(negedge mclk);
    #2 user_reset2 = 1'b0;
    pll_lock = lock_val;
    sw_reset_req = 1'b0;
    cycles(3);
    user_reset2 = 1'b1;
  endtask

  // Wait (on the model's view) until the sequence reaches at least state s.
  task automatic wait_model_state(input int s, input int budget, input string tag);
    int n = 0;
    while (m_state() < s && n < budget) begin
      @(negedge mclk);
      n++;
    end
    if (m_state() < s) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_sw();
    sw_reset_req = 1'b1;
    @(negedge mclk);
    sw_reset_req = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int cnt, prev_loss, dwell;
    user_reset2 = 1'b0;
    pll_lock = 1'b1;
    sw_reset_req = 1'b0;
    cycles(3);
    check_eq("reset_sync", 32'(sync_reset_n), 32'd0);
    check_eq("reset_state", 32'(seq_state), 32'd0);
    check_eq("reset_loss", 32'(lock_loss_cnt), 32'd0);
    user_reset2 = 1'b1;

    // Test 1: default timing with lock high throughout.
    for (int k = 1; k <= 51; k++) begin
      @(negedge mclk);
      if (k == 26) check_eq("t1_edge26", 32'(sync_reset_n), 32'h0);
      if (k == 27) check_eq("t1_edge27", 32'(sync_reset_n), 32'h1);
      if (k == 35) check_eq("t1_edge35", 32'(sync_reset_n), 32'h3);
      if (k == 43) check_eq("t1_edge43", 32'(sync_reset_n), 32'h7);
      if (k == 50) check_eq("t1_done50", 32'(rst_done), 32'd0);
      if (k == 51) begin
        check_eq("t1_edge51", 32'(sync_reset_n), 32'hF);
        check_eq("t1_done51", 32'(rst_done), 32'd1);
        check_eq("t1_run", 32'(seq_state), 32'd4);
      end
    end

    // Test 3: one-cycle lock drop in RUN.
    pll_lock = 1'b0;
    @(negedge mclk);
    pll_lock = 1'b1;
    cnt = 1;
    while (sync_reset_n != '0 && cnt < 10) begin
      @(negedge mclk);
      cnt++;
    end
    check_eq("t3_within4", 32'(cnt <= 4), 32'd1);
    check_eq("t3_loss1", 32'(lock_loss_cnt), 32'd1);
`ifdef RST_CAUSE_EN
    check_eq("t3_cause", 32'(rst_cause), 32'd1);
`endif
    wait_model_state(4, 200, "t3_rerun");
    check_eq("t3_rerun_sync", 32'(sync_reset_n), 32'hF);

    // Test 4: software reset pulse in RUN.
    pulse_sw();
    check_eq("t4_sync0", 32'(sync_reset_n), 32'h0);
    check_eq("t4_state", 32'(seq_state), 32'd2);
`ifdef RST_CAUSE_EN
    check_eq("t4_cause", 32'(rst_cause), 32'd2);
`endif
    cycles(15);
    check_eq("t4_pre_rel", 32'(sync_reset_n), 32'h0);
    cycles(1);
    check_eq("t4_rel", 32'(sync_reset_n), 32'h1);
    wait_model_state(4, 200, "t4_rerun");

    // Test 5: software request on the same edge lock_ok falls.
    prev_loss = int'(lock_loss_cnt);
    pll_lock = 1'b0;
    cnt = 0;
    while (m_lock_ok() && cnt < 10) begin
      @(negedge mclk);
      cnt++;
    end
    sw_reset_req = 1'b1;
    pll_lock = 1'b1;
    @(negedge mclk);
    sw_reset_req = 1'b0;
    check_eq("t5_state", 32'(seq_state), 32'd1);
    check_eq("t5_loss", 32'(lock_loss_cnt), 32'(prev_loss + 1));

    // Test 2: lock rises 40 edges after reset release.
    do_reset(1'b0);
    cycles(40);
    check_eq("t2_waitlock", 32'(seq_state), 32'd1);
    pll_lock = 1'b1;
    cnt = 0;
    while (sync_reset_n[0] !== 1'b1 && cnt < 60) begin
      @(negedge mclk);
      cnt++;
    end
    check_eq("t2_latency", 32'(cnt >= 26 && cnt <= 28), 32'd1);

    // Random phase: lock glitches and software requests.
    dwell = 40;
    for (int i = 0; i < 3000; i++) begin
      @(negedge mclk);
      if (dwell == 0) begin
        pll_lock = ~pll_lock;
        dwell = pll_lock ? $urandom_range(5, 120) : $urandom_range(1, 6);
      end else begin
        dwell--;
      end
      sw_reset_req = ($urandom_range(0, 59) == 0);
    end
    sw_reset_req = 1'b0;
    pll_lock = 1'b1;

    // Test 6: user_reset2 mid-RELEASE, then saturate the lock-loss counter.
    do_reset(1'b1);
    cnt = 0;
    while (m_sync() != ND'(3) && cnt < 200) begin
      @(negedge mclk);
      cnt++;
    end
    check_eq("t6_at_0011", 32'(sync_reset_n), 32'h3);
    #2 user_reset2 = 1'b0;
    #1;
    check_eq("t6_async_sync", 32'(sync_reset_n), 32'h0);
    check_eq("t6_async_done", 32'(rst_done), 32'd0);
    check_eq("t6_async_state", 32'(seq_state), 32'd0);
    check_eq("t6_async_loss", 32'(lock_loss_cnt), 32'd0);
    cycles(2);
    user_reset2 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_model_state(3, 200, "t6_loop");
      pll_lock = 1'b0;
      @(negedge mclk);
      pll_lock = 1'b1;
      cycles(4);
    end
    check_eq("t6_saturate", 32'(lock_loss_cnt), 32'd255);

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
